fast_pattern_sme_stream_ctrl: RTL and testbench
===============================================

FAST_PATTERN_SME_STREAM_CTRL -- requirements
Module: fast_pattern_sme_stream_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst, synchronous, active-high.
REQ-002 Parameters SHALL be as listed below.
- HIST_BYTES, default 7: history/preamble depth in bytes (1..15).
- BIN_COUNT, default 8: encoder bins.
- IDX_W, default 13: match index width.
- CNT_W, default 16: statistics counter width.
REQ-003 Ports SHALL be as listed below.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  byte valid (no backpressure).
- preamble_state  in  (HIST_BYTES+1)*8  byte i at [i*8+:8], i=1..HIST_BYTES; length in [7:0].
- reload  in  1  new-packet pulse.
- sme_tdata  out  8  byte to matcher.
- sme_tvalid  out  1  byte valid to matcher.
- sme_rst  out  1  matcher reset.
- bin_valid  in  BIN_COUNT  per-bin match from encoder.
- bin_index  in  BIN_COUNT*IDX_W  per-bin index.
- bin_error  in  BIN_COUNT  per-bin multi-hit error.
- m_match_index  out  IDX_W  reported index.
- m_match_error  out  1  reported error flag.
- m_match_valid  out  1  match output valid.
- m_match_ready  in  1  consumer ready.
- last_bytes_state  out  (HIST_BYTES+1)*8  same layout as preamble_state.
- match_count  out  CNT_W  matches delivered this packet.
- drop_count  out  CNT_W  cycles with lost matches this packet.
- overflow  out  1  sticky: match lost this packet.

Function
REQ-004 On reload, replay_ptr SHALL load preamble_state length, clamped to HIST_BYTES.
REQ-005 While replay_ptr>0, sme_tdata SHALL be preamble_state[replay_ptr*8+:8] and sme_tvalid SHALL be 1; replay_ptr SHALL decrement each cycle (oldest byte first).
REQ-006 While replay_ptr==0, sme_tdata/sme_tvalid SHALL pass s_axis_tdata/s_axis_tvalid combinationally; input bytes arriving during replay SHALL be ignored by the matcher.
REQ-007 sme_rst SHALL equal rst|reload combinationally.
REQ-008 On each s_axis_tvalid, history SHALL shift: newest byte to slot 1, slot i to slot i+1, and hist_len SHALL increment, saturating at HIST_BYTES; replayed bytes SHALL NOT enter history.
REQ-009 last_bytes_state slot i SHALL equal history slot i, with [7:0]={zero pad, hist_len}.
REQ-010 reload or rst SHALL clear hist_len to 0; this SHALL take priority over a same-cycle increment. Data bytes still shift.
REQ-011 Drain FSM states SHALL be IDLE and DRAIN.
REQ-012 In IDLE with |bin_valid, the block SHALL snapshot bin_valid/bin_index/bin_error into pend/idx/err and go to DRAIN.
REQ-013 In DRAIN, m_match_valid SHALL be 1, reporting the lowest-numbered set pend bit's idx/err.
REQ-014 On m_match_valid&m_match_ready, that pend bit SHALL clear and match_count SHALL increment; if it was the last bit, the FSM SHALL return to IDLE.
REQ-015 Latency SHALL be bin_valid at cycle N -> m_match_valid at N+1; IDLE SHALL last at least one cycle between snapshots.
REQ-016 Outputs SHALL be held stable while m_match_valid & !m_match_ready.
REQ-017 In DRAIN with |bin_valid, drop_count SHALL increment and overflow SHALL set.
REQ-018 match_count and drop_count SHALL saturate at all-ones.
REQ-019 reload SHALL clear pend, counters and overflow, and force IDLE, aborting any pending output; this is the only permitted withdrawal of m_match_valid without handshake.
REQ-020 A reload-cycle bin_valid SHALL be ignored.

Reset
REQ-021 rst SHALL set the FSM to IDLE, pend=0, replay_ptr=0, hist_len=0, m_match_valid=0, counters=0 and overflow=0; history data bytes need no reset.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and width helper functions (clog2, length-field width).
REQ-023 Replay mux plus history SHALL be one sub-module, fast_pattern_sme_byte_history; the drain FSM and counters SHALL stay in the top.

Verification
REQ-024 Reload with length=3 and bytes 0x11,0x22,0x33 in slots 1..3 -> sme_tdata 0x33,0x22,0x11 on 3 consecutive cycles, then passthrough.
REQ-025 Stream 10 bytes 0x01..0x0A -> last_bytes_state slot1=0x0A, slot7=0x04, length 7.
REQ-026 bin_valid=8'b1000_0101 with indices 5,9,20 and m_match_ready held high -> indices 5, 9, 20 on 3 consecutive cycles; match_count=3.
REQ-027 Hold m_match_ready low 4 cycles during DRAIN -> outputs stable; bin_valid pulse in that window -> drop_count=1, overflow=1.
REQ-028 Reload mid-DRAIN with 2 matches pending -> next cycle m_match_valid=0, counters=0, overflow=0, length=0.

Source files
------------

// File: rtl/fast_pattern_sme_stream_ctrl_pkg.sv
// Shared types and width helpers for the SME stream controller slice.
package fast_pattern_sme_stream_ctrl_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} drain_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bits needed to hold a history length of 0..hist_bytes.
  function automatic int len_w(input int hist_bytes);
    return (clog2(hist_bytes + 1) < 1) ? 1 : clog2(hist_bytes + 1);
  endfunction

endpackage

// File: rtl/fast_pattern_sme_stream_ctrl_if.sv
// Match-report stream: controller drives index/error/valid, consumer drives ready.
interface fast_pattern_sme_stream_ctrl_if
  import fast_pattern_sme_stream_ctrl_pkg::*;
#(
  parameter int IDX_W = 13
);
  logic [IDX_W-1:0] m_match_index;
  logic             m_match_error;
  logic             m_match_valid;
  logic             m_match_ready;

  modport master (output m_match_index, output m_match_error, output m_match_valid,
                  input  m_match_ready);
  modport slave  (input  m_match_index, input  m_match_error, input  m_match_valid,
                  output m_match_ready);
endinterface

// File: rtl/fast_pattern_sme_byte_history.sv
// Preamble replay mux in front of the matcher plus the rolling byte history.
module fast_pattern_sme_byte_history
  import fast_pattern_sme_stream_ctrl_pkg::*;
#(
  parameter int HIST_BYTES = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reload,
  input  logic [7:0]                  s_tdata,
  input  logic                        s_tvalid,
  input  logic [(HIST_BYTES+1)*8-1:0] preamble_state,
  output logic [7:0]                  sme_tdata,
  output logic                        sme_tvalid,
  output logic [(HIST_BYTES+1)*8-1:0] last_bytes_state
);
  localparam int PTR_W = len_w(HIST_BYTES);

  logic [PTR_W-1:0]             replay_ptr_q, replay_ptr_d;
  logic [PTR_W-1:0]             hist_len_q, hist_len_d;
  logic [HIST_BYTES:1][7:0]     hist_q, hist_d;

  always_comb begin
    replay_ptr_d = replay_ptr_q;
    if (reload)
      replay_ptr_d = (preamble_state[7:0] > 8'(HIST_BYTES)) ? PTR_W'(HIST_BYTES)
                                                            : preamble_state[PTR_W-1:0];
    else if (replay_ptr_q != '0)
      replay_ptr_d = replay_ptr_q - 1'b1;

    hist_d     = hist_q;
    hist_len_d = hist_len_q;
    if (s_tvalid) begin
      for (int i = HIST_BYTES; i >= 2; i--) hist_d[i] = hist_q[i-1];
      hist_d[1] = s_tdata;
      if (hist_len_q != PTR_W'(HIST_BYTES)) hist_len_d = hist_len_q + 1'b1;
    end
    // A new packet restarts the length even if a byte lands in the same cycle.
    if (reload) hist_len_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      replay_ptr_q <= '0;
      hist_len_q   <= '0;
    end else begin
      replay_ptr_q <= replay_ptr_d;
      hist_len_q   <= hist_len_d;
    end
  end

  always_ff @(posedge clk) hist_q <= hist_d;

  // Live bytes arriving during replay never reach the matcher.
  always_comb begin
    if (replay_ptr_q != '0) begin
      sme_tdata  = preamble_state[{replay_ptr_q, 3'b000} +: 8];
      sme_tvalid = 1'b1;
    end else begin
      sme_tdata  = s_tdata;
      sme_tvalid = s_tvalid;
    end
  end

  always_comb begin
    last_bytes_state      = '0;
    last_bytes_state[7:0] = 8'(hist_len_q);
    for (int i = 1; i <= HIST_BYTES; i++) last_bytes_state[i*8 +: 8] = hist_q[i];
  end

endmodule

// File: rtl/fast_pattern_sme_stream_ctrl.sv
// SME stream controller: preamble replay/history front end and match drain with stats.
module fast_pattern_sme_stream_ctrl
  import fast_pattern_sme_stream_ctrl_pkg::*;
#(
  parameter int HIST_BYTES = 7,
  parameter int BIN_COUNT  = 8,
  parameter int IDX_W      = 13,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic [(HIST_BYTES+1)*8-1:0]   preamble_state,
  input  logic                          reload,
  output logic [7:0]                    sme_tdata,
  output logic                          sme_tvalid,
  output logic                          sme_rst,
  input  logic [BIN_COUNT-1:0]          bin_valid,
  input  logic [BIN_COUNT*IDX_W-1:0]    bin_index,
  input  logic [BIN_COUNT-1:0]          bin_error,
  fast_pattern_sme_stream_ctrl_if.master m_match,
  output logic [(HIST_BYTES+1)*8-1:0]   last_bytes_state,
  output logic [CNT_W-1:0]              match_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          overflow
);
  localparam int SEL_W = (clog2(BIN_COUNT) < 1) ? 1 : clog2(BIN_COUNT);

  assign sme_rst = rst | reload;

  fast_pattern_sme_byte_history #(.HIST_BYTES(HIST_BYTES)) u_hist (
    .clk              (clk),
    .rst              (rst),
    .reload           (reload),
    .s_tdata          (s_axis_tdata),
    .s_tvalid         (s_axis_tvalid),
    .preamble_state   (preamble_state),
    .sme_tdata        (sme_tdata),
    .sme_tvalid       (sme_tvalid),
    .last_bytes_state (last_bytes_state)
  );

  drain_state_e                        state_q, state_d;
  logic [BIN_COUNT-1:0]                pend_q, pend_d;
  logic [BIN_COUNT-1:0][IDX_W-1:0]     idx_q, idx_d;
  logic [BIN_COUNT-1:0]                err_q, err_d;
  logic [CNT_W-1:0]                    match_count_q, match_count_d;
  logic [CNT_W-1:0]                    drop_count_q, drop_count_d;
  logic                                overflow_q, overflow_d;
  logic [SEL_W-1:0]                    sel;
  logic                                found;
  logic                                hs;

  // Lowest-numbered pending bin is reported first.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < BIN_COUNT; i++) begin
      if (pend_q[i] && !found) begin
        sel   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  assign m_match.m_match_valid = (state_q == DRAIN);
  assign m_match.m_match_index = idx_q[sel];
  assign m_match.m_match_error = err_q[sel];
  assign hs = m_match.m_match_valid & m_match.m_match_ready;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    idx_d         = idx_q;
    err_d         = err_q;
    match_count_d = match_count_q;
    drop_count_d  = drop_count_q;
    overflow_d    = overflow_q;
    case (state_q)
      IDLE: begin
        if (|bin_valid) begin
          pend_d  = bin_valid;
          idx_d   = bin_index;
          err_d   = bin_error;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          pend_d[sel] = 1'b0;
          if (~&match_count_q) match_count_d = match_count_q + 1'b1;
          if (pend_d == '0) state_d = IDLE;
        end
        // The snapshot is busy, so anything the encoder reports now is lost.
        if (|bin_valid) begin
          if (~&drop_count_q) drop_count_d = drop_count_q + 1'b1;
          overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reload) begin
      state_d       = IDLE;
      pend_d        = '0;
      match_count_d = '0;
      drop_count_d  = '0;
      overflow_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      match_count_q <= '0;
      drop_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      match_count_q <= match_count_d;
      drop_count_q  <= drop_count_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    err_q <= err_d;
  end

  assign match_count = match_count_q;
  assign drop_count  = drop_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fast_pattern_sme_stream_ctrl.sv
// Directed bench for the SME stream controller: replay, history and match drain.
module tb_fast_pattern_sme_stream_ctrl;
  localparam int HB = 7, BC = 8, IW = 13, CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid;
  logic [(HB+1)*8-1:0]  preamble_state;
  logic                 reload;
  logic [7:0]           sme_tdata;
  logic                 sme_tvalid;
  logic                 sme_rst;
  logic [BC-1:0]        bin_valid;
  logic [BC-1:0][IW-1:0] bidx;
  logic [BC-1:0]        bin_error;
  logic [(HB+1)*8-1:0]  last_bytes_state;
  logic [CW-1:0]        match_count;
  logic [CW-1:0]        drop_count;
  logic                 overflow;

  int errors = 0;
  int checks = 0;

  fast_pattern_sme_stream_ctrl_if #(.IDX_W(IW)) mif ();

  fast_pattern_sme_stream_ctrl #(.HIST_BYTES(HB), .BIN_COUNT(BC), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .preamble_state   (preamble_state),
    .reload           (reload),
    .sme_tdata        (sme_tdata),
    .sme_tvalid       (sme_tvalid),
    .sme_rst          (sme_rst),
    .bin_valid        (bin_valid),
    .bin_index        (bidx),
    .bin_error        (bin_error),
    .m_match          (mif.master),
    .last_bytes_state (last_bytes_state),
    .match_count      (match_count),
    .drop_count       (drop_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; reload = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    preamble_state = '0; bin_valid = '0; bidx = '0; bin_error = '0;
    mif.m_match_ready = 1'b0;
    tick(); tick();
    chk("rst_sme_rst", 64'(sme_rst), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(mif.m_match_valid), 64'd0);
    chk("rst_match_count", 64'(match_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_len", 64'(last_bytes_state[7:0]), 64'd0);
    chk("idle_sme_rst", 64'(sme_rst), 64'd0);

    // Replay of a 3-byte preamble; live byte in the reload cycle passes through.
    preamble_state = '0;
    preamble_state[7:0] = 8'd3;
    preamble_state[15:8] = 8'h11; preamble_state[23:16] = 8'h22; preamble_state[31:24] = 8'h33;
    reload = 1'b1; s_axis_tdata = 8'hEE; s_axis_tvalid = 1'b1;
    #1;
    chk("reload_sme_rst", 64'(sme_rst), 64'd1);
    chk("reload_pass", 64'(sme_tdata), 64'hEE);
    tick();
    reload = 1'b0; s_axis_tvalid = 1'b0;
    #1;
    chk("replay0", 64'(sme_tdata), 64'h33);
    chk("replay0_v", 64'(sme_tvalid), 64'd1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hBB;
    tick();
    chk("replay1", 64'(sme_tdata), 64'h22);
    s_axis_tvalid = 1'b0;
    tick();
    chk("replay2", 64'(sme_tdata), 64'h11);
    tick();
    chk("pass_idle_v", 64'(sme_tvalid), 64'd0);
    s_axis_tdata = 8'h5A; s_axis_tvalid = 1'b1;
    #1;
    chk("pass_data", 64'(sme_tdata), 64'h5A);
    chk("pass_v", 64'(sme_tvalid), 64'd1);
    s_axis_tvalid = 1'b0;

    // Length beyond HIST_BYTES is clamped: replay starts at slot 7.
    preamble_state[7:0] = 8'd9;
    for (int i = 1; i <= HB; i++) preamble_state[i*8 +: 8] = 8'hA0 + 8'(i);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    chk("clamp_first", 64'(sme_tdata), 64'hA7);
    for (int i = 0; i < 6; i++) tick();
    chk("clamp_last", 64'(sme_tdata), 64'hA1);
    tick();
    chk("clamp_done_v", 64'(sme_tvalid), 64'd0);

    // History fill: 10 bytes, saturating length.
    preamble_state = '0;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int b = 1; b <= 10; b++) begin
      s_axis_tdata = 8'(b); s_axis_tvalid = 1'b1;
      tick();
      if (b == 3) chk("hist_len3", 64'(last_bytes_state[7:0]), 64'd3);
    end
    s_axis_tvalid = 1'b0;
    tick();
    chk("hist_slot1", 64'(last_bytes_state[15:8]), 64'h0A);
    chk("hist_slot7", 64'(last_bytes_state[63:56]), 64'h04);
    chk("hist_len", 64'(last_bytes_state[7:0]), 64'd7);

    // Reload wins over a same-cycle increment, but the byte still shifts in.
    reload = 1'b1; s_axis_tdata = 8'h77; s_axis_tvalid = 1'b1;
    tick();
    reload = 1'b0; s_axis_tvalid = 1'b0;
    #1;
    chk("rl_len", 64'(last_bytes_state[7:0]), 64'd0);
    chk("rl_slot1", 64'(last_bytes_state[15:8]), 64'h77);
    chk("rl_slot2", 64'(last_bytes_state[23:16]), 64'h0A);

    // Drain three matches back to back.
    for (int i = 0; i < BC; i++) bidx[i] = 13'h1FFF;
    bidx[0] = 13'd5; bidx[2] = 13'd9; bidx[7] = 13'd20;
    bin_error = 8'b0000_0100;
    bin_valid = 8'b1000_0101;
    mif.m_match_ready = 1'b1;
    tick();
    bin_valid = '0;
    #1;
    chk("d_v0", 64'(mif.m_match_valid), 64'd1);
    chk("d_idx0", 64'(mif.m_match_index), 64'd5);
    chk("d_err0", 64'(mif.m_match_error), 64'd0);
    tick();
    chk("d_idx1", 64'(mif.m_match_index), 64'd9);
    chk("d_err1", 64'(mif.m_match_error), 64'd1);
    tick();
    chk("d_idx2", 64'(mif.m_match_index), 64'd20);
    tick();
    chk("d_done", 64'(mif.m_match_valid), 64'd0);
    chk("d_count", 64'(match_count), 64'd3);
    chk("d_no_drop", 64'(drop_count), 64'd0);

    // Backpressure: outputs hold, a bin pulse during DRAIN is dropped.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    mif.m_match_ready = 1'b0;
    bidx[1] = 13'd100; bidx[3] = 13'd200; bin_error = '0;
    bin_valid = 8'b0000_1010;
    tick();
    bin_valid = '0;
    #1;
    chk("bp_idx_a", 64'(mif.m_match_index), 64'd100);
    bin_valid = 8'h01;
    tick();
    bin_valid = '0;
    chk("bp_idx_b", 64'(mif.m_match_index), 64'd100);
    tick();
    chk("bp_v", 64'(mif.m_match_valid), 64'd1);
    chk("bp_drop", 64'(drop_count), 64'd1);
    chk("bp_ovf", 64'(overflow), 64'd1);
    tick();
    chk("bp_idx_c", 64'(mif.m_match_index), 64'd100);
    chk("bp_count", 64'(match_count), 64'd0);
    mif.m_match_ready = 1'b1;
    tick();
    chk("bp_idx_next", 64'(mif.m_match_index), 64'd200);
    chk("bp_count1", 64'(match_count), 64'd1);
    tick();
    chk("bp_idle", 64'(mif.m_match_valid), 64'd0);
    chk("bp_drop_keep", 64'(drop_count), 64'd1);

    // Reload mid-DRAIN aborts; a reload-cycle bin_valid is ignored.
    mif.m_match_ready = 1'b0;
    bin_valid = 8'b0000_1010;
    tick();
    bin_valid = 8'h01;
    #1;
    chk("ab_v_before", 64'(mif.m_match_valid), 64'd1);
    reload = 1'b1;
    tick();
    reload = 1'b0; bin_valid = '0;
    #1;
    chk("ab_v", 64'(mif.m_match_valid), 64'd0);
    chk("ab_count", 64'(match_count), 64'd0);
    chk("ab_drop", 64'(drop_count), 64'd0);
    chk("ab_ovf", 64'(overflow), 64'd0);
    chk("ab_len", 64'(last_bytes_state[7:0]), 64'd0);
    tick();
    chk("ab_v_stay", 64'(mif.m_match_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
